wd_window_timer: RTL
====================

Name: wd_window_timer

Overview:
Windowed watchdog timer that sits directly upstream of the watchdog fail detector. It times the firmware service window, converts a valid firmware kick into a clean WDSRVC pulse, and asserts FWOVR on a window violation (missed or early kick). The fail detector consumes WDSRVC and FWOVR.

Parameters:
CNT_W, 16, width of the window counter.
CLOSED_CYC, 100, length of the closed (no-kick-allowed) window in cycles; legal range 1..2^CNT_W-1.
OPEN_CYC, 400, length of the open (kick-required) window in cycles; legal range 1..2^CNT_W-1.
SRVC_CYC, 4, WDSRVC pulse width in cycles; legal range 1..2^CNT_W-1.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  watchdog enable; level.
KICK  input  1  firmware service strobe; sampled each cycle, 1-cycle pulse expected.
WDSRVC  output  1  service pulse to the fail detector; registered.
FWOVR  output  1  window violation flag to the fail detector; registered, sticky.
CAUSE  output  2  violation cause: 00 none, 01 early kick, 10 open-window timeout.
WIN_OPEN  output  1  high while in OPEN.
SRVC_CNT  output  8  count of accepted services, saturating at 255.

Behaviour:
- States: IDLE, CLOSED, OPEN, SERVICE, OVERRUN. One counter (CNT_W bits) is shared by CLOSED, OPEN and SERVICE and is cleared on every state entry.
- Reset (RST=1 at an edge): state IDLE, counter 0, WDSRVC=0, FWOVR=0, CAUSE=00, WIN_OPEN=0, SRVC_CNT=0. RST has priority over all other inputs, including mid-SERVICE and OVERRUN.
- EN=0 in any state except OVERRUN: next state is IDLE and WDSRVC and WIN_OPEN are 0 from the next cycle. A WDSRVC pulse is truncated, not completed.
- IDLE: KICK is ignored. EN=1 -> CLOSED.
- CLOSED: lasts exactly CLOSED_CYC cycles (counter 0..CLOSED_CYC-1).
  - KICK in any CLOSED cycle, including the last -> OVERRUN with CAUSE=01.
  - At counter=CLOSED_CYC-1 with no KICK -> OPEN.
- OPEN: WIN_OPEN=1 for exactly OPEN_CYC cycles.
  - KICK -> SERVICE. KICK wins on the terminal cycle (counter=OPEN_CYC-1).
  - Counter=OPEN_CYC-1 with no KICK -> OVERRUN with CAUSE=10.
- SERVICE: KICK sampled in OPEN at cycle t gives WDSRVC=1 in cycles t+1..t+SRVC_CYC, then 0, then CLOSED.
  - SRVC_CNT increments once, on SERVICE entry, and holds at 255.
  - KICK during SERVICE is ignored, with no violation.
- OVERRUN: FWOVR=1 and CAUSE held from the cycle after the violating edge. WDSRVC=0, WIN_OPEN=0.
  - Exit only by RST. EN is ignored.
- FWOVR and CAUSE change only on entry to OVERRUN or on RST. WDSRVC is never high in the same cycle as FWOVR.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
1. CLOSED_CYC=4, OPEN_CYC=8, SRVC_CYC=2. RST, then EN=1; KICK on the 3rd OPEN cycle -> WIN_OPEN high for 3 cycles, WDSRVC high exactly 2 cycles, SRVC_CNT=1, FWOVR=0, state back to CLOSED.
2. KICK on the 2nd CLOSED cycle -> next cycle FWOVR=1, CAUSE=01, WDSRVC stays 0. Toggle EN=0 -> FWOVR remains 1 until RST.
3. No KICK -> WIN_OPEN high for 8 cycles, then FWOVR=1, CAUSE=10. Repeat with KICK on the 8th OPEN cycle -> SERVICE, FWOVR=0.
4. Boundary kicks:
   - KICK on the last CLOSED cycle (counter=3) -> CAUSE=01.
   - KICK on the first OPEN cycle -> accepted.
   - Extra KICK mid-SERVICE -> ignored, SRVC_CNT increments by exactly 1.
5. Disturb during service:
   - EN dropped in the 1st WDSRVC cycle -> WDSRVC=0 next cycle, state IDLE. Re-enable -> CLOSED with counter 0.
   - RST asserted mid-SERVICE -> all outputs at reset values next cycle.
6. 300 consecutive valid services -> SRVC_CNT saturates at 255, no FWOVR.

Source files
------------

// File: rtl/wd_window_timer.sv
// Windowed watchdog timer: enforces a closed/open kick window, turns a valid kick into a
// WDSRVC pulse and raises a sticky FWOVR with a cause code on a missed or early kick.
module wd_window_timer #(
   parameter int CNT_W      = 16,
   parameter int CLOSED_CYC = 100,
   parameter int OPEN_CYC   = 400,
   parameter int SRVC_CYC   = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic       KICK,
   output logic       WDSRVC,
   output logic       FWOVR,
   output logic [1:0] CAUSE,
   output logic       WIN_OPEN,
   output logic [7:0] SRVC_CNT,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLOSED  = 3'd1,
      S_OPEN    = 3'd2,
      S_SERVICE = 3'd3,
      S_OVERRUN = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LP_CLOSED_LAST = CNT_W'(CLOSED_CYC - 1);
   localparam logic [CNT_W-1:0] LP_OPEN_LAST   = CNT_W'(OPEN_CYC - 1);
   localparam logic [CNT_W-1:0] LP_SRVC_LAST   = CNT_W'(SRVC_CYC - 1);
   localparam logic [CNT_W-1:0] LP_ONE         = CNT_W'(1);

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_EARLY = 2'b01;
   localparam logic [1:0] CAUSE_LATE  = 2'b10;

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       w_next_cause;
   logic             r_wdsrvc;
   logic             r_fwovr;
   logic [1:0]       r_cause;
   logic             r_win_open;
   logic [7:0]       r_srvc_cnt;

   always_comb begin
      w_next_state = r_state;
      w_next_cause = r_cause;
      case (r_state)
         S_IDLE: begin
            if (EN) w_next_state = S_CLOSED;
         end
         S_CLOSED: begin
            if (KICK) begin
               w_next_state = S_OVERRUN;
               w_next_cause = CAUSE_EARLY;
            end else if (r_cnt == LP_CLOSED_LAST) begin
               w_next_state = S_OPEN;
            end
         end
         S_OPEN: begin
            // A kick on the terminal open cycle is still a valid service.
            if (KICK) begin
               w_next_state = S_SERVICE;
            end else if (r_cnt == LP_OPEN_LAST) begin
               w_next_state = S_OVERRUN;
               w_next_cause = CAUSE_LATE;
            end
         end
         S_SERVICE: begin
            if (r_cnt == LP_SRVC_LAST) w_next_state = S_CLOSED;
         end
         S_OVERRUN: begin
            w_next_state = S_OVERRUN;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
      // Disable aborts everything except a latched violation.
      if (!EN && (r_state != S_OVERRUN)) begin
         w_next_state = S_IDLE;
         w_next_cause = r_cause;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_wdsrvc   <= 1'b0;
         r_fwovr    <= 1'b0;
         r_cause    <= CAUSE_NONE;
         r_win_open <= 1'b0;
         r_srvc_cnt <= 8'd0;
      end else begin
         r_state <= w_next_state;
         if ((w_next_state != r_state) || (w_next_state == S_IDLE)) begin
            r_cnt <= '0;
         end else if (r_state != S_OVERRUN) begin
            r_cnt <= r_cnt + LP_ONE;
         end
         r_wdsrvc   <= (w_next_state == S_SERVICE);
         r_win_open <= (w_next_state == S_OPEN);
         r_fwovr    <= (w_next_state == S_OVERRUN);
         r_cause    <= w_next_cause;
         if ((w_next_state == S_SERVICE) && (r_state != S_SERVICE) && (r_srvc_cnt != 8'hFF)) begin
            r_srvc_cnt <= r_srvc_cnt + 8'd1;
         end
      end
   end

   assign WDSRVC      = r_wdsrvc;
   assign FWOVR       = r_fwovr;
   assign CAUSE       = r_cause;
   assign WIN_OPEN    = r_win_open;
   assign SRVC_CNT    = r_srvc_cnt;
   assign o_dbg_state = r_state;

endmodule
